// File: rtl/meteor_field_if.sv
// Tile-scan, hit and status signals between meteor_field and the game/VGA side.
interface meteor_field_if #(
    parameter int c_NumMet = 4
);
    // No valid/ready pair: the scan tile is sampled every clock, i_Hit is a one-cycle
    // strobe qualified by i_HitIdx, and every output is registered status (o_Landed a pulse).
    logic [5:0]          i_ColCountDiv;
    logic [5:0]          i_RowCountDiv;
    logic                i_Hit;
    logic [2:0]          i_HitIdx;
    logic                o_DrawMet;
    logic [2:0]          o_MetIdx;
    logic                o_Landed;
    logic [c_NumMet-1:0] o_ActiveMask;

    modport master (
        output i_ColCountDiv, i_RowCountDiv, i_Hit, i_HitIdx,
        input  o_DrawMet, o_MetIdx, o_Landed, o_ActiveMask
    );

    modport slave (
        input  i_ColCountDiv, i_RowCountDiv, i_Hit, i_HitIdx,
        output o_DrawMet, o_MetIdx, o_Landed, o_ActiveMask
    );
endinterface

// File: rtl/meteor_field.sv
// Multi-slot meteorite controller: shared step timer, wobbling fall, LFSR respawn,
// hit/landing retirement and a registered tile-draw lookup.
module meteor_field #(
    parameter int          c_NumMet         = 4,
    parameter int          c_GameWidth      = 40,
    parameter int          c_GameHeight     = 30,
    parameter int          c_MeteoriteSpeed = 4000000,
    parameter int          c_SpawnSteps     = 8,
    parameter logic [15:0] c_LfsrSeed       = 16'hACE1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    input  logic          i_GameActive,
    meteor_field_if.slave mf
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FALL = 1'b1;

    localparam logic [15:0] c_Seed   = (c_LfsrSeed == 16'h0000) ? 16'h0001 : c_LfsrSeed;
    localparam int          c_SpawnW = $clog2(c_SpawnSteps + 1);

    localparam logic [31:0]         c_StepLast  = 32'(c_MeteoriteSpeed - 1);
    localparam logic [c_SpawnW-1:0] c_SpawnLast = c_SpawnW'(c_SpawnSteps - 1);
    localparam logic [5:0]          c_XMax      = 6'(c_GameWidth - 1);
    localparam logic [5:0]          c_YMax      = 6'(c_GameHeight - 1);
    localparam logic [5:0]          c_Width     = 6'(c_GameWidth);

    logic [15:0]         r_Lfsr;
    logic [31:0]         r_StepCnt;
    logic [c_SpawnW-1:0] r_SpawnCnt;
    logic [0:0]          r_State   [c_NumMet];
    logic [5:0]          r_X       [c_NumMet];
    logic [5:0]          r_Y       [c_NumMet];
    logic                r_DirLeft [c_NumMet];
    logic                r_Landed;
    logic                r_DrawMet;
    logic [2:0]          r_MetIdx;

    logic                w_Step;
    logic                w_SpawnNow;
    logic [5:0]          w_SpawnX;
    logic                w_FreeFound;
    logic [2:0]          w_FreeIdx;
    logic [c_NumMet-1:0] w_Active;
    logic [c_NumMet-1:0] w_Hit;
    logic [c_NumMet-1:0] w_GoLeft;
    logic                w_Draw;
    logic [2:0]          w_DrawIdx;

    // Galois form, taps x^16+x^14+x^13+x^11; free-running so spawn columns differ per game.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Lfsr <= c_Seed;
        end else begin
            r_Lfsr <= {1'b0, r_Lfsr[15:1]} ^ (r_Lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_Step     = (r_StepCnt == c_StepLast);
    assign w_SpawnNow = w_Step && (r_SpawnCnt == c_SpawnLast);
    assign w_SpawnX   = (r_Lfsr[5:0] < c_Width) ? r_Lfsr[5:0] : r_Lfsr[5:0] - c_Width;

    // Descending scans leave the lowest matching index in the priority results.
    always_comb begin
        w_Active    = '0;
        w_Hit       = '0;
        w_GoLeft    = '0;
        w_FreeFound = 1'b0;
        w_FreeIdx   = 3'd0;
        w_Draw      = 1'b0;
        w_DrawIdx   = 3'd0;
        for (int i = c_NumMet - 1; i >= 0; i--) begin
            w_Active[i] = (r_State[i] == ST_FALL);
            w_Hit[i]    = mf.i_Hit && (mf.i_HitIdx == 3'(i));
            w_GoLeft[i] = (r_X[i] == c_XMax) ? 1'b1 :
                          (r_X[i] == 6'd0)   ? 1'b0 : r_DirLeft[i];
            if (!w_Active[i]) begin
                w_FreeFound = 1'b1;
                w_FreeIdx   = 3'(i);
            end
            if (w_Active[i] && r_X[i] == mf.i_ColCountDiv && r_Y[i] == mf.i_RowCountDiv) begin
                w_Draw    = 1'b1;
                w_DrawIdx = 3'(i);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_StepCnt  <= '0;
            r_SpawnCnt <= '0;
            r_Landed   <= 1'b0;
            for (int i = 0; i < c_NumMet; i++) begin
                r_State[i]   <= ST_IDLE;
                r_X[i]       <= 6'd0;
                r_Y[i]       <= 6'd0;
                r_DirLeft[i] <= 1'b0;
            end
        end else if (!i_GameActive) begin
            r_StepCnt  <= '0;
            r_SpawnCnt <= '0;
            r_Landed   <= 1'b0;
            for (int i = 0; i < c_NumMet; i++) begin
                r_State[i]   <= ST_IDLE;
                r_X[i]       <= 6'd0;
                r_Y[i]       <= 6'd0;
                r_DirLeft[i] <= 1'b0;
            end
        end else begin
            r_Landed <= 1'b0;
            if (w_Step) begin
                r_StepCnt  <= '0;
                r_SpawnCnt <= w_SpawnNow ? '0 : r_SpawnCnt + c_SpawnW'(1);
            end else begin
                r_StepCnt <= r_StepCnt + 32'd1;
            end
            // Free-slot choice uses pre-edge state, so a slot retired on this edge waits.
            for (int i = 0; i < c_NumMet; i++) begin
                if (r_State[i] == ST_FALL) begin
                    if (w_Hit[i]) begin
                        r_State[i] <= ST_IDLE;
                    end else if (w_Step) begin
                        if (r_Y[i] == c_YMax) begin
                            r_State[i] <= ST_IDLE;
                            r_Landed   <= 1'b1;
                        end else begin
                            r_Y[i]       <= r_Y[i] + 6'd1;
                            r_X[i]       <= w_GoLeft[i] ? r_X[i] - 6'd1 : r_X[i] + 6'd1;
                            r_DirLeft[i] <= ~w_GoLeft[i];
                        end
                    end
                end else if (w_SpawnNow && w_FreeFound && w_FreeIdx == 3'(i)) begin
                    r_State[i]   <= ST_FALL;
                    r_X[i]       <= w_SpawnX;
                    r_Y[i]       <= 6'd0;
                    r_DirLeft[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_DrawMet <= 1'b0;
            r_MetIdx  <= 3'd0;
        end else if (!i_GameActive) begin
            r_DrawMet <= 1'b0;
            r_MetIdx  <= 3'd0;
        end else begin
            r_DrawMet <= w_Draw;
            r_MetIdx  <= w_DrawIdx;
        end
    end

    assign mf.o_ActiveMask = w_Active;
    assign mf.o_DrawMet    = r_DrawMet;
    assign mf.o_MetIdx     = r_MetIdx;
    assign mf.o_Landed     = r_Landed;
endmodule

// File: tb/tb_meteor_field.sv
// Directed bench for meteor_field: 2 slots, 4-clock steps, spawn every 2 steps, 4 rows.
module tb_meteor_field;
  logic clk;
  logic rst_n;
  logic game_active;
  int   n_cmp;
  int   n_err;
  int   e;
  logic [15:0] m_lfsr;
  logic [5:0]  sx;

  meteor_field_if #(.c_NumMet(2)) mf ();

  meteor_field #(
    .c_NumMet(2), .c_GameWidth(40), .c_GameHeight(4),
    .c_MeteoriteSpeed(4), .c_SpawnSteps(2), .c_LfsrSeed(16'hACE1)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_GameActive(game_active), .mf(mf.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // reference LFSR: right-shift Galois, mask 16'hB400, seed 16'hACE1
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [5:0] x_of(input logic [15:0] v);
    return (v[5:0] < 6'd40) ? v[5:0] : v[5:0] - 6'd40;
  endfunction

  function automatic logic [15:0] adv7(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int k = 0; k < 7; k++) t = lfsr_adv(t);
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_adv(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic goto(input int k);
    while (e < k) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic scan(input logic [5:0] col, input logic [5:0] row);
    mf.i_ColCountDiv = col;
    mf.i_RowCountDiv = row;
  endtask

  // Start play at the moment the 8th following edge will spawn at column tgt.
  task automatic arm(input logic [5:0] tgt);
    int tries;
    tries = 0;
    while (x_of(adv7(m_lfsr)) != tgt && tries < 4000) begin
      @(negedge clk);
      tries++;
    end
    check("arm_col", 32'(x_of(adv7(m_lfsr))), 32'(tgt));
    game_active = 1'b1;
    e = 0;
  endtask

  task automatic stop_play();
    game_active = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    e = 0;
    rst_n = 1'b0;
    game_active = 1'b0;
    mf.i_Hit = 1'b0;
    mf.i_HitIdx = 3'd0;
    scan(6'd0, 6'd0);
    repeat (2) @(negedge clk);
    check("rst_mask", 32'(mf.o_ActiveMask), 32'h0);
    check("rst_draw", 32'(mf.o_DrawMet), 32'h0);
    check("rst_idx", 32'(mf.o_MetIdx), 32'h0);
    check("rst_landed", 32'(mf.o_Landed), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // spawn, wobble (10,0)->(11,1)->(10,2)->(11,3), landing, hit handling
    arm(6'd10);
    goto(7);  check("no_early_spawn", 32'(mf.o_ActiveMask), 32'h0);
    goto(8);  check("spawn_slot0", 32'(mf.o_ActiveMask), 32'h1);
    scan(6'd10, 6'd0);
    goto(9);  check("draw_10_0", 32'(mf.o_DrawMet), 32'h1);
              check("idx_10_0", 32'(mf.o_MetIdx), 32'h0);
    goto(12); scan(6'd11, 6'd1);
    goto(13); check("draw_11_1", 32'(mf.o_DrawMet), 32'h1);
    goto(15); sx = x_of(m_lfsr);
    goto(16); check("spawn_slot1", 32'(mf.o_ActiveMask), 32'h3);
    scan(sx, 6'd0);
    mf.i_Hit = 1'b1; mf.i_HitIdx = 3'd5;
    goto(17); check("draw_slot1", 32'(mf.o_DrawMet), 32'h1);
              check("idx_slot1", 32'(mf.o_MetIdx), 32'h1);
              check("hit_idx5_ignored", 32'(mf.o_ActiveMask), 32'h3);
    mf.i_Hit = 1'b0;
    scan(sx, 6'd3);
    goto(18); check("draw_empty", 32'(mf.o_DrawMet), 32'h0);
              check("idx_empty", 32'(mf.o_MetIdx), 32'h0);
    scan(6'd10, 6'd2);
    goto(19); check("draw_10_2", 32'(mf.o_DrawMet), 32'h1);
              check("idx_10_2", 32'(mf.o_MetIdx), 32'h0);
    goto(20); scan(6'd11, 6'd3);
    goto(21); check("draw_11_3", 32'(mf.o_DrawMet), 32'h1);
    scan((sx == 6'd39) ? 6'd38 : sx + 6'd1, 6'd1);
    goto(22); check("draw_slot1_step", 32'(mf.o_DrawMet), 32'h1);
              check("idx_slot1_step", 32'(mf.o_MetIdx), 32'h1);
    goto(23); check("landed_before", 32'(mf.o_Landed), 32'h0);
    goto(24); check("landed_pulse", 32'(mf.o_Landed), 32'h1);
              check("full_spawn_dropped", 32'(mf.o_ActiveMask), 32'h2);
    mf.i_Hit = 1'b1; mf.i_HitIdx = 3'd0;
    goto(25); check("landed_one_cycle", 32'(mf.o_Landed), 32'h0);
              check("hit_idle_noop", 32'(mf.o_ActiveMask), 32'h2);
    mf.i_Hit = 1'b0;
    goto(31); mf.i_Hit = 1'b1; mf.i_HitIdx = 3'd1;
    goto(32); mf.i_Hit = 1'b0;
              check("hit_beats_step", 32'(mf.o_ActiveMask), 32'h1);
              check("hit_no_landed", 32'(mf.o_Landed), 32'h0);
    goto(33); check("hit_no_landed_late", 32'(mf.o_Landed), 32'h0);

    stop_play();
    check("inactive_mask", 32'(mf.o_ActiveMask), 32'h0);
    check("inactive_draw", 32'(mf.o_DrawMet), 32'h0);

    // right edge: 39 moving +1 turns to 38
    arm(6'd39);
    goto(8);  scan(6'd39, 6'd0);
    goto(9);  check("draw_39_0", 32'(mf.o_DrawMet), 32'h1);
    goto(12); scan(6'd38, 6'd1);
    goto(13); check("edge_right", 32'(mf.o_DrawMet), 32'h1);
    stop_play();

    // left edge: 0 steps to 1
    arm(6'd0);
    goto(8);  scan(6'd0, 6'd0);
    goto(9);  check("draw_0_0", 32'(mf.o_DrawMet), 32'h1);
    goto(12); scan(6'd1, 6'd1);
    goto(13); check("edge_left", 32'(mf.o_DrawMet), 32'h1);
    stop_play();

    // asynchronous reset with both slots active
    game_active = 1'b1;
    e = 0;
    goto(15); sx = x_of(m_lfsr);
    goto(16); check("both_active", 32'(mf.o_ActiveMask), 32'h3);
    scan(sx, 6'd0);
    goto(17); check("draw_pre_reset", 32'(mf.o_DrawMet), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mask", 32'(mf.o_ActiveMask), 32'h0);
    check("async_rst_draw", 32'(mf.o_DrawMet), 32'h0);
    check("async_rst_idx", 32'(mf.o_MetIdx), 32'h0);
    game_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
